// File: rtl/proc_pkg.sv
// Shared definitions for the boot-time program loader: data/address widths
// and the loader state encoding.
package proc_pkg;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned CNT_W  = WORD_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    GET_LEN,
    GET_DATA,
    WR,
    GET_CHK,
    RUN,
    ERR
  } loader_state_e;

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog for the loader: counts enabled cycles since the last clear
// and flags expiry on the cycle the count reaches TIMEOUT (TIMEOUT=0 disables it).
module loader_timeout #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  if (TIMEOUT == 0) begin : g_off
    logic unused_in;
    assign unused_in = clk ^ rst ^ clr ^ en;
    assign expired   = 1'b0;
  end else begin : g_cnt
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          hit;

    // Expiry fires on the TIMEOUT-th idle cycle so the caller leaves on that edge.
    always_comb begin
      hit   = en && (cnt_q == CW'(TIMEOUT - 1));
      cnt_d = cnt_q;
      if (clr || hit) begin
        cnt_d = '0;
      end else if (en) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign expired = hit;
  end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: accepts a LEN/data/CHK frame over valid/ready,
// writes it to program memory and releases the CPU only once the checksum matches.
module prog_loader
  import proc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h00,
  parameter int unsigned       TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_data,
  output logic              mem_write,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_data_q, mem_data_d;
  logic [WORD_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              hs;
  logic              to_expired;

  assign in_ready = (state_q == GET_LEN) || (state_q == GET_DATA) || (state_q == GET_CHK);
  assign hs       = in_valid && in_ready;

  // The watchdog only runs while waiting for a byte; WR and the idle states hold it clear.
  loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_ready || hs),
    .en      (in_ready && !hs),
    .expired (to_expired)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE, RUN, ERR: begin
        if (start) begin
          state_d = GET_LEN;
          addr_d  = BASE_ADDR;
          sum_d   = '0;
        end
      end
      GET_LEN: begin
        if (hs) begin
          // LEN=0 encodes a full 256-byte image.
          cnt_d   = {(in_data == '0), in_data};
          state_d = GET_DATA;
        end else if (to_expired) begin
          state_d = ERR;
        end
      end
      GET_DATA: begin
        if (hs) begin
          mem_data_d = in_data;
          mem_addr_d = addr_q;
          sum_d      = sum_q + in_data;
          state_d    = WR;
        end else if (to_expired) begin
          state_d = ERR;
        end
      end
      WR: begin
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == CNT_W'(1)) ? GET_CHK : GET_DATA;
      end
      GET_CHK: begin
        if (hs) begin
          state_d = (in_data == sum_q) ? RUN : ERR;
        end else if (to_expired) begin
          state_d = ERR;
        end
      end
      default: state_d = IDLE;
    endcase

    cpu_rst_d = (state_d != RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= BASE_ADDR;
      mem_addr_q <= BASE_ADDR;
      mem_data_q <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      cpu_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign mem_write = (state_q == WR);
  assign cpu_rst   = cpu_rst_q;
  assign busy      = in_ready || (state_q == WR);
  assign done      = (state_q == RUN);
  assign error     = (state_q == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (base 00/timeout 16, base F0/no timeout)
// driven with directed and randomized frames, checked against a frame-level model.
module tb_prog_loader;

  localparam int unsigned TO0   = 16;
  localparam logic [7:0]  BASE1 = 8'hF0;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i    [2];
  logic       in_valid_i [2];
  logic [7:0] in_data_i  [2];
  logic       in_ready_o [2];
  logic [7:0] mem_addr_o [2];
  logic [7:0] mem_data_o [2];
  logic       mem_write_o[2];
  logic       cpu_rst_o  [2];
  logic       busy_o     [2];
  logic       done_o     [2];
  logic       error_o    [2];

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] wrq0[$];
  logic [15:0] wrq1[$];
  logic        prev_mw[2];

  always #5 clk = ~clk;

  prog_loader #(.BASE_ADDR(8'h00), .TIMEOUT(TO0)) dut0 (
    .clk(clk), .rst(rst), .start(start_i[0]), .in_valid(in_valid_i[0]), .in_data(in_data_i[0]),
    .in_ready(in_ready_o[0]), .mem_addr(mem_addr_o[0]), .mem_data(mem_data_o[0]),
    .mem_write(mem_write_o[0]), .cpu_rst(cpu_rst_o[0]), .busy(busy_o[0]),
    .done(done_o[0]), .error(error_o[0])
  );

  prog_loader #(.BASE_ADDR(BASE1), .TIMEOUT(0)) dut1 (
    .clk(clk), .rst(rst), .start(start_i[1]), .in_valid(in_valid_i[1]), .in_data(in_data_i[1]),
    .in_ready(in_ready_o[1]), .mem_addr(mem_addr_o[1]), .mem_data(mem_data_o[1]),
    .mem_write(mem_write_o[1]), .cpu_rst(cpu_rst_o[1]), .busy(busy_o[1]),
    .done(done_o[1]), .error(error_o[1])
  );

  // Write monitor: records every strobe; a write must be one cycle wide with in_ready low.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_write_o[d] === 1'b1) begin
        n_cmp++;
        assert (in_ready_o[d] === 1'b0 && prev_mw[d] !== 1'b1)
        else begin
          n_err++;
          $error("FAIL wr_strobe dut%0d: in_ready=%b prev_write=%b expected 0/0",
                 d, in_ready_o[d], prev_mw[d]);
        end
        if (d == 0) wrq0.push_back({mem_addr_o[d], mem_data_o[d]});
        else        wrq1.push_back({mem_addr_o[d], mem_data_o[d]});
      end
      prev_mw[d] = mem_write_o[d];
    end
  end

  initial begin
    #500000;
    $fatal(1, "FAIL watchdog: simulation time limit expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sum8(input logic [7:0] q[$]);
    int s = 0;
    foreach (q[i]) s += int'(q[i]);
    return 8'(s % 256);
  endfunction

  task automatic check_reset(input int d, input string pfx);
    logic [7:0] base;
    base = (d == 1) ? BASE1 : 8'h00;
    chk({pfx, "_cpu_rst"},   {31'd0, cpu_rst_o[d]},   32'd1);
    chk({pfx, "_in_ready"},  {31'd0, in_ready_o[d]},  32'd0);
    chk({pfx, "_mem_write"}, {31'd0, mem_write_o[d]}, 32'd0);
    chk({pfx, "_mem_addr"},  {24'd0, mem_addr_o[d]},  {24'd0, base});
    chk({pfx, "_mem_data"},  {24'd0, mem_data_o[d]},  32'd0);
    chk({pfx, "_busy"},      {31'd0, busy_o[d]},      32'd0);
    chk({pfx, "_done"},      {31'd0, done_o[d]},      32'd0);
    chk({pfx, "_error"},     {31'd0, error_o[d]},     32'd0);
  endtask

  task automatic pulse_start(input int d);
    start_i[d] = 1'b1;
    @(negedge clk);
    start_i[d] = 1'b0;
  endtask

  // Offers one byte and returns at the negedge after it is accepted.
  task automatic send_byte(input int d, input logic [7:0] b, input bit gaps);
    bit ok;
    ok = 1'b0;
    if (gaps) begin
      int g;
      g = $urandom_range(0, 2);
      if (g > 0) begin
        in_valid_i[d] = 1'b0;
        repeat (g) @(negedge clk);
      end
    end
    in_valid_i[d] = 1'b1;
    in_data_i[d]  = b;
    for (int i = 0; i < 64; i++) begin
      if (in_ready_o[d] === 1'b1) begin
        @(posedge clk);
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("handshake_dut%0d", d), {31'd0, ok}, 32'd1);
  endtask

  // Full frame: start, LEN, data, CHK; then checks outcome flags and the write log.
  task automatic send_frame(input int d, input logic [7:0] len, input logic [7:0] data[$],
                            input logic [7:0] chk_b, input bit gaps, input int start_mid,
                            input string tag);
    logic [7:0]  base;
    logic [15:0] q[$];
    int          n;
    bit          good;
    base = (d == 1) ? BASE1 : 8'h00;
    n    = (len == 8'h00) ? 256 : int'(len);
    good = (sum8(data) == chk_b);
    if (d == 0) wrq0.delete();
    else        wrq1.delete();

    pulse_start(d);
    chk({tag, "_start_ready"},   {31'd0, in_ready_o[d]}, 32'd1);
    chk({tag, "_start_busy"},    {31'd0, busy_o[d]},     32'd1);
    chk({tag, "_start_cpu_rst"}, {31'd0, cpu_rst_o[d]},  32'd1);
    chk({tag, "_start_done"},    {31'd0, done_o[d]},     32'd0);

    send_byte(d, len, gaps);
    for (int i = 0; i < n; i++) begin
      send_byte(d, data[i], gaps);
      if (i == start_mid) pulse_start(d);
    end
    send_byte(d, chk_b, gaps);
    in_valid_i[d] = 1'b0;

    chk({tag, "_done"},     {31'd0, done_o[d]},     {31'd0, good});
    chk({tag, "_error"},    {31'd0, error_o[d]},    {31'd0, !good});
    chk({tag, "_cpu_rst"},  {31'd0, cpu_rst_o[d]},  {31'd0, !good});
    chk({tag, "_busy"},     {31'd0, busy_o[d]},     32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready_o[d]}, 32'd0);

    if (d == 0) q = wrq0;
    else        q = wrq1;
    chk({tag, "_wr_count"}, q.size(), n);
    for (int i = 0; i < n && i < q.size(); i++) begin
      chk($sformatf("%s_wr_addr%0d", tag, i), {24'd0, q[i][15:8]}, {24'd0, 8'(int'(base) + i)});
      chk($sformatf("%s_wr_data%0d", tag, i), {24'd0, q[i][7:0]},  {24'd0, data[i]});
    end
  endtask

  initial begin
    logic [7:0] data[$];
    logic [7:0] len;
    logic [7:0] c;
    int         cyc;

    for (int d = 0; d < 2; d++) begin
      start_i[d]    = 1'b0;
      in_valid_i[d] = 1'b0;
      in_data_i[d]  = 8'h00;
      prev_mw[d]    = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset(0, "rst0");
    check_reset(1, "rst1");

    // Nominal load
    data = '{8'h11, 8'h22, 8'h33};
    send_frame(0, 8'h03, data, 8'h66, 1'b0, -1, "nominal");

    // Bad checksum
    data = '{8'h05, 8'h06};
    send_frame(0, 8'h02, data, 8'h0A, 1'b0, -1, "badchk");

    // LEN=0 from base F0: 256 bytes wrapping through FF -> 00 .. EF
    data.delete();
    for (int i = 0; i < 256; i++) data.push_back(8'(i));
    send_frame(1, 8'h00, data, 8'h80, 1'b0, -1, "wrap");

    // Timeout in GET_DATA after one of four bytes
    pulse_start(0);
    send_byte(0, 8'h04, 1'b0);
    send_byte(0, 8'hA5, 1'b0);
    in_valid_i[0] = 1'b0;
    cyc = 25;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i == 8) chk("to_early_error", {31'd0, error_o[0]}, 32'd0);
      if (error_o[0] === 1'b1) begin
        cyc = i;
        break;
      end
    end
    chk("to_latency_in_window", {31'd0, (cyc >= int'(TO0) && cyc <= int'(TO0) + 2)}, 32'd1);
    chk("to_error",   {31'd0, error_o[0]},   32'd1);
    chk("to_busy",    {31'd0, busy_o[0]},    32'd0);
    chk("to_cpu_rst", {31'd0, cpu_rst_o[0]}, 32'd1);
    chk("to_done",    {31'd0, done_o[0]},    32'd0);

    data = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(0, 8'h04, data, 8'h0A, 1'b0, -1, "after_to");

    // Mid-frame start pulse with in_valid held high across WR
    data = '{8'h9C, 8'h47, 8'hE1, 8'h30, 8'h0F};
    send_frame(0, 8'h05, data, sum8(data), 1'b0, 1, "midstart");

    // Randomized frames, some with corrupted checksum and idle gaps
    for (int f = 0; f < 6; f++) begin
      len = 8'($urandom_range(1, 24));
      data.delete();
      for (int i = 0; i < int'(len); i++) data.push_back(8'($urandom));
      c = sum8(data);
      if ($urandom_range(0, 2) == 0) c = c ^ 8'($urandom_range(1, 255));
      send_frame(0, len, data, c, 1'b1, -1, $sformatf("rand%0d", f));
    end
    len = 8'($urandom_range(1, 16));
    data.delete();
    for (int i = 0; i < int'(len); i++) data.push_back(8'($urandom));
    send_frame(1, len, data, sum8(data), 1'b1, -1, "rand_b1");

    // Reset asserted mid-load after the second data byte has been written
    wrq0.delete();
    pulse_start(0);
    send_byte(0, 8'h05, 1'b0);
    send_byte(0, 8'hC3, 1'b0);
    send_byte(0, 8'h3C, 1'b0);
    in_valid_i[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset(0, "midrst");
    chk("midrst_wr_count", wrq0.size(), 2);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    data = '{8'hDE, 8'hAD, 8'hBE};
    send_frame(0, 8'h03, data, sum8(data), 1'b0, -1, "after_rst");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
